// File: rtl/psrv_pipe_pkg.sv
// Shared definitions for the PSRV32 pipeline hazard controller.
//   REG_ADDR_W     : register address width
//   REG_X0         : index of the hard-wired zero register
//   MC_TIMEOUT_DEF : default multi-cycle busy limit in cycles
//   pipe_state_e   : sequencer FSM states (RUN, MC_WAIT)
package psrv_pipe_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;
   localparam int MC_TIMEOUT_DEF = 64;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } pipe_state_e;

endpackage

// File: rtl/psrv_scoreboard.sv
// Register scoreboard: one saturating in-flight counter per architectural
// register, bumped when an instruction writing that register issues and
// dropped when the write retires in WB.
// Ports:
//   clk_i, reset_i      : clock, asynchronous active-low reset
//   inc_i, inc_rd_i     : issue of a writer of inc_rd_i
//   dec_i, dec_rd_i     : WB write of dec_rd_i
//   rs1_i, rs2_i        : read-port addresses
//   rs1_busy_o/rs2_busy_o : addressed register has a write in flight
// x0 is never tracked and always reads as not busy.
module psrv_scoreboard
   import psrv_pipe_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int SB_CNT_W = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  inc_i,
   input  logic [REG_ADDR_W-1:0] inc_rd_i,
   input  logic                  dec_i,
   input  logic [REG_ADDR_W-1:0] dec_rd_i,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   output logic                  rs1_busy_o,
   output logic                  rs2_busy_o
);

   localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

   logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
   logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r != 0) begin
            // Simultaneous issue and retire of the same register cancel out.
            if (inc_i && (inc_rd_i == REG_ADDR_W'(r)) &&
                !(dec_i && (dec_rd_i == REG_ADDR_W'(r)))) begin
               if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_i && (dec_rd_i == REG_ADDR_W'(r)) &&
                         !(inc_i && (inc_rd_i == REG_ADDR_W'(r)))) begin
               if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
         end else begin
            cnt_d[r] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      end
   end

   assign rs1_busy_o = (rs1_i != REG_X0) && (cnt_q[rs1_i] != '0);
   assign rs2_busy_o = (rs2_i != REG_X0) && (cnt_q[rs2_i] != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the PSRV32 5-stage pipeline.
// Detects RAW hazards on the decode instruction, holds the front end while
// a multi-cycle EX op is busy, and squashes wrong-path work on redirect.
// Ports:
//   clk_i, reset_i                 : clock, asynchronous active-low reset
//   id_*                           : decode-stage instruction fields
//   ex_rd_i, ex_is_load_i          : EX destination / load flag
//   ex_mc_start_i, ex_mc_done_i    : multi-cycle op start / result ready
//   ex_redirect_i                  : taken branch/jump resolved in EX
//   wb_rd_i, wb_we_i               : WB register write
//   stall_if_o, stall_id_o         : hold PC+IF/ID and the ID stage
//   bubble_ex_o, flush_id_o        : NOP into ID/EX, kill IF/ID
//   mc_busy_o, mc_timeout_o        : MC op in progress, sticky timeout error
// Build option: define PSRV_HAZARD_FWD_EN when a full forwarding network is
// present; only load-use then stalls and the scoreboard is debug-only.
// Valid/ready note: an instruction "issues" from ID in a cycle where
// id_valid_i is high and neither stall_id_o nor flush_id_o is asserted.
module pipeline_hazard_ctrl
   import psrv_pipe_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
   parameter int SB_CNT_W   = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_rs1_use_i,
   input  logic                  id_rs2_use_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_rd_we_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_is_load_i,
   input  logic                  ex_mc_start_i,
   input  logic                  ex_mc_done_i,
   input  logic                  ex_redirect_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic                  wb_we_i,
   output logic                  stall_if_o,
   output logic                  stall_id_o,
   output logic                  bubble_ex_o,
   output logic                  flush_id_o,
   output logic                  mc_busy_o,
   output logic                  mc_timeout_o
);

   localparam int TO_CNT_W = $clog2(MC_TIMEOUT + 1);
   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(MC_TIMEOUT - 1);
   localparam logic [TO_CNT_W-1:0] TO_ONE  = TO_CNT_W'(1);

   pipe_state_e         state_q, state_d;
   logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic                to_flag_q, to_flag_d;

   logic rs1_busy, rs2_busy;
   logic raw;
   logic stall, bubble, flush;
   logic issue;

   assign issue = id_valid_i & ~stall & ~flush;

   psrv_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .SB_CNT_W (SB_CNT_W)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (issue & id_rd_we_i),
      .inc_rd_i   (id_rd_i),
      .dec_i      (wb_we_i),
      .dec_rd_i   (wb_rd_i),
      .rs1_i      (id_rs1_i),
      .rs2_i      (id_rs2_i),
      .rs1_busy_o (rs1_busy),
      .rs2_busy_o (rs2_busy)
   );

`ifdef PSRV_HAZARD_FWD_EN
   // Everything except a load result in EX can be forwarded.
   logic unused_sb;
   assign unused_sb = &{1'b0, rs1_busy, rs2_busy};
   assign raw = id_valid_i & ex_is_load_i & (ex_rd_i != REG_X0) &
                ((id_rs1_use_i & (ex_rd_i == id_rs1_i)) |
                 (id_rs2_use_i & (ex_rd_i == id_rs2_i)));
`else
   logic unused_ex;
   assign unused_ex = &{1'b0, ex_rd_i, ex_is_load_i};
   assign raw = id_valid_i & ((id_rs1_use_i & rs1_busy) |
                              (id_rs2_use_i & rs2_busy));
`endif

   always_comb begin
      logic run_like;
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      to_flag_d = to_flag_q;
      stall     = 1'b0;
      bubble    = 1'b0;
      flush     = 1'b0;
      run_like  = 1'b1;

      if (state_q == MC_WAIT) begin
         if (ex_mc_done_i) begin
            // Front end is released in the done cycle itself.
            state_d  = RUN;
            to_cnt_d = '0;
         end else begin
            // EX is owned by the MC unit, so no bubble is needed here.
            run_like = 1'b0;
            stall    = 1'b1;
            if (to_cnt_q == TO_LAST) begin
               to_flag_d = 1'b1;
               state_d   = RUN;
               to_cnt_d  = '0;
            end else begin
               to_cnt_d = to_cnt_q + TO_ONE;
            end
         end
      end

      if (run_like) begin
         if (ex_redirect_i) begin
            // Redirect beats both RAW stalls and a (illegal) concurrent MC start.
            flush  = 1'b1;
            bubble = 1'b1;
         end else if (ex_mc_start_i) begin
            state_d  = MC_WAIT;
            to_cnt_d = '0;
         end else if (raw) begin
            stall  = 1'b1;
            bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= RUN;
         to_cnt_q  <= '0;
         to_flag_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_d;
      end
   end

   // Outputs are forced low while reset is held, whatever the inputs do.
   assign stall_if_o   = reset_i & stall;
   assign stall_id_o   = reset_i & stall;
   assign bubble_ex_o  = reset_i & bubble;
   assign flush_id_o   = reset_i & flush;
   assign mc_busy_o    = reset_i & (state_q == MC_WAIT);
   assign mc_timeout_o = to_flag_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int MC_TIMEOUT = 64;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       id_valid_i;
   logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
   logic       id_rs1_use_i, id_rs2_use_i, id_rd_we_i;
   logic [4:0] ex_rd_i;
   logic       ex_is_load_i, ex_mc_start_i, ex_mc_done_i, ex_redirect_i;
   logic [4:0] wb_rd_i;
   logic       wb_we_i;
   logic       stall_if_o, stall_id_o, bubble_ex_o, flush_id_o;
   logic       mc_busy_o, mc_timeout_o;

   pipeline_hazard_ctrl dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .id_valid_i    (id_valid_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_rs1_use_i  (id_rs1_use_i),
      .id_rs2_use_i  (id_rs2_use_i),
      .id_rd_i       (id_rd_i),
      .id_rd_we_i    (id_rd_we_i),
      .ex_rd_i       (ex_rd_i),
      .ex_is_load_i  (ex_is_load_i),
      .ex_mc_start_i (ex_mc_start_i),
      .ex_mc_done_i  (ex_mc_done_i),
      .ex_redirect_i (ex_redirect_i),
      .wb_rd_i       (wb_rd_i),
      .wb_we_i       (wb_we_i),
      .stall_if_o    (stall_if_o),
      .stall_id_o    (stall_id_o),
      .bubble_ex_o   (bubble_ex_o),
      .flush_id_o    (flush_id_o),
      .mc_busy_o     (mc_busy_o),
      .mc_timeout_o  (mc_timeout_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   wire [5:0] obs = {stall_if_o, stall_id_o, bubble_ex_o, flush_id_o,
                     mc_busy_o, mc_timeout_o};

   int n_vec = 0;
   int n_err = 0;
   logic [5:0] exp_q[$];

   // ---------------- reference model ----------------
   // In-flight write count per register, whether an MC op owns EX, how long
   // it has been waiting, and the sticky timeout flag.
   int sb [32];
   bit m_busy;
   int m_wait;
   bit m_to;
   bit e_stall, e_bubble, e_flush;

   function automatic void model_reset();
      for (int r = 0; r < 32; r++) sb[r] = 0;
      m_busy = 0;
      m_wait = 0;
      m_to   = 0;
   endfunction

   function automatic bit model_raw();
`ifdef PSRV_HAZARD_FWD_EN
      return id_valid_i && ex_is_load_i && (ex_rd_i != 0) &&
             ((id_rs1_use_i && ex_rd_i == id_rs1_i) ||
              (id_rs2_use_i && ex_rd_i == id_rs2_i));
`else
      return id_valid_i &&
             ((id_rs1_use_i && id_rs1_i != 0 && sb[id_rs1_i] > 0) ||
              (id_rs2_use_i && id_rs2_i != 0 && sb[id_rs2_i] > 0));
`endif
   endfunction

   function automatic void model_eval();
      bit held;
      held = m_busy && !ex_mc_done_i;
      e_stall = 0; e_bubble = 0; e_flush = 0;
      if (held) e_stall = 1;
      else if (ex_redirect_i) begin e_flush = 1; e_bubble = 1; end
      else if (ex_mc_start_i) ;
      else if (model_raw()) begin e_stall = 1; e_bubble = 1; end
   endfunction

   function automatic logic [5:0] exp_vec();
      return {e_stall, e_stall, e_bubble, e_flush, m_busy, m_to};
   endfunction

   function automatic void model_commit();
      bit issue, held;
      int n;
      issue = id_valid_i && !e_stall && !e_flush;
      held  = m_busy && !ex_mc_done_i;
      for (int r = 1; r < 32; r++) begin
         n = sb[r];
         if (issue && id_rd_we_i && id_rd_i == r) n = n + 1;
         if (wb_we_i && wb_rd_i == r) n = n - 1;
         if (n > 3) n = 3;
         if (n < 0) n = 0;
         sb[r] = n;
      end
      if (held) begin
         m_wait = m_wait + 1;
         if (m_wait == MC_TIMEOUT) begin
            m_to = 1; m_busy = 0; m_wait = 0;
         end
      end else begin
         m_busy = ex_mc_start_i && !ex_redirect_i;
         m_wait = 0;
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rs1_use_i = 0;
      id_rs2_use_i = 0; id_rd_i = 0; id_rd_we_i = 0; ex_rd_i = 0;
      ex_is_load_i = 0; ex_mc_start_i = 0; ex_mc_done_i = 0;
      ex_redirect_i = 0; wb_rd_i = 0; wb_we_i = 0;
   endtask

   task automatic drive_id(input bit v, input int rs1, input bit u1,
                           input int rs2, input bit u2, input int rd, input bit we);
      id_valid_i = v; id_rs1_i = 5'(rs1); id_rs1_use_i = u1;
      id_rs2_i = 5'(rs2); id_rs2_use_i = u2; id_rd_i = 5'(rd); id_rd_we_i = we;
   endtask

   task automatic drive_random();
      id_valid_i    = ($urandom_range(3) != 0);
      id_rs1_i      = 5'($urandom_range(7));
      id_rs2_i      = 5'($urandom_range(7));
      id_rs1_use_i  = 1'($urandom_range(1));
      id_rs2_use_i  = 1'($urandom_range(1));
      id_rd_i       = 5'($urandom_range(7));
      id_rd_we_i    = 1'($urandom_range(1));
      ex_rd_i       = 5'($urandom_range(7));
      ex_is_load_i  = ($urandom_range(3) == 0);
      ex_mc_start_i = ($urandom_range(19) == 0);
      ex_mc_done_i  = ($urandom_range(5) == 0);
      ex_redirect_i = ($urandom_range(7) == 0);
      wb_rd_i       = 5'($urandom_range(7));
      wb_we_i       = 1'($urandom_range(1));
   endtask

   task automatic settle();
      @(negedge clk_i);
      model_eval();
   endtask

   task automatic advance();
      model_commit();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_i = 0;
      drive_idle();
      model_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      n_vec++;
      if (obs !== 6'b0) begin
         n_err++;
         $display("FAIL reset_state: got %b want %b", obs, 6'b0);
      end
      reset_i = 1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_raw_stall();
      int stall_cycles = 0;
      for (int c = 0; c < 7; c++) begin
         drive_idle();
         if (c == 0) drive_id(1, 0, 0, 0, 0, 5, 1);  // add x5
         else        drive_id(1, 5, 1, 0, 0, 6, 1);  // reads x5
         if (c == 4) begin wb_we_i = 1; wb_rd_i = 5; end
         settle();
         if (stall_if_o) stall_cycles++;
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL raw_stall cyc %0d: got %b want %b", c, obs, exp_vec());
         end
         advance();
      end
`ifndef PSRV_HAZARD_FWD_EN
      // Stall on the four cycles up to and including the WB of x5.
      n_vec++;
      if (stall_cycles != 4) begin
         n_err++;
         $display("FAIL raw_stall_len: got %0d want %0d", stall_cycles, 4);
      end
`endif
      // Drain x6 written by the reader.
      drive_idle(); wb_we_i = 1; wb_rd_i = 6;
      settle(); advance();
   endtask

   task automatic test_load_use();
      for (int c = 0; c < 4; c++) begin
         drive_idle();
         drive_id(1, 0, 0, 7, 1, 0, 0);
         ex_rd_i = 7;
         ex_is_load_i = (c == 0);     // load in EX only for one cycle
         settle();
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL load_use cyc %0d: got %b want %b", c, obs, exp_vec());
         end
         advance();
      end
   endtask

   task automatic test_mc_done();
      int busy_cycles = 0;
      for (int c = 0; c < 13; c++) begin
         drive_idle();
         drive_id(1, 1, 1, 2, 1, 0, 0);
         ex_mc_start_i = (c == 0);
         ex_mc_done_i  = (c == 10);
         settle();
         if (mc_busy_o) busy_cycles++;
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL mc_done cyc %0d: got %b want %b", c, obs, exp_vec());
         end
         advance();
      end
      n_vec++;
      if (busy_cycles != 10) begin
         n_err++;
         $display("FAIL mc_busy_len: got %0d want %0d", busy_cycles, 10);
      end
   endtask

   task automatic test_redirect_raw();
      for (int c = 0; c < 5; c++) begin
         drive_idle();
         if (c == 0) drive_id(1, 0, 0, 0, 0, 3, 1);
         else        drive_id(1, 3, 1, 0, 0, 0, 0);
         ex_redirect_i = (c == 2);
         if (c == 3) begin wb_we_i = 1; wb_rd_i = 3; end
         settle();
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL redirect_raw cyc %0d: got %b want %b", c, obs, exp_vec());
         end
         if (c == 2) begin
            n_vec++;
            if ({flush_id_o, bubble_ex_o, stall_if_o} !== 3'b110) begin
               n_err++;
               $display("FAIL redirect_prio: got %b want %b",
                        {flush_id_o, bubble_ex_o, stall_if_o}, 3'b110);
            end
         end
         advance();
      end
   endtask

   task automatic test_same_cycle_x9();
      for (int c = 0; c < 5; c++) begin
         drive_idle();
         case (c)
            0: drive_id(1, 0, 0, 0, 0, 9, 1);
            1: begin drive_id(1, 0, 0, 0, 0, 9, 1); wb_we_i = 1; wb_rd_i = 9; end
            2: drive_id(1, 0, 0, 9, 1, 0, 0);
            3: begin drive_id(1, 0, 0, 9, 1, 0, 0); wb_we_i = 1; wb_rd_i = 9; end
            default: drive_id(1, 0, 0, 9, 1, 0, 0);
         endcase
         settle();
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL same_cycle_x9 cyc %0d: got %b want %b", c, obs, exp_vec());
         end
         advance();
      end
   endtask

   task automatic test_mc_timeout();
      int busy_cycles = 0;
      for (int c = 0; c < 72; c++) begin
         drive_idle();
         ex_mc_start_i = (c == 0);
         settle();
         if (mc_busy_o) busy_cycles++;
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL mc_timeout cyc %0d: got %b want %b", c, obs, exp_vec());
         end
         advance();
      end
      n_vec++;
      if (busy_cycles != MC_TIMEOUT || mc_timeout_o !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_flag: got busy %0d flag %b want busy %0d flag 1",
                  busy_cycles, mc_timeout_o, MC_TIMEOUT);
      end
      // Flag stays set across a later, well-behaved MC op.
      for (int c = 0; c < 5; c++) begin
         drive_idle();
         ex_mc_start_i = (c == 0);
         ex_mc_done_i  = (c == 3);
         settle();
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL timeout_sticky cyc %0d: got %b want %b", c, obs, exp_vec());
         end
         advance();
      end
      @(negedge clk_i);
      reset_i = 0;
      #1;
      n_vec++;
      if (mc_timeout_o !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_clear: got %b want 0", mc_timeout_o);
      end
      model_reset();
      @(posedge clk_i);
      #1;
      reset_i = 1;
   endtask

   task automatic test_reset_mid_mc();
      for (int c = 0; c < 4; c++) begin
         drive_idle();
         if (c == 0) drive_id(1, 0, 0, 0, 0, 12, 1);
         ex_mc_start_i = (c == 1);
         settle();
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL pre_reset cyc %0d: got %b want %b", c, obs, exp_vec());
         end
         advance();
      end
      drive_id(1, 12, 1, 0, 0, 0, 0);
      ex_redirect_i = 1;
      @(negedge clk_i);
      reset_i = 0;
      #1;
      n_vec++;
      if (obs !== 6'b0) begin
         n_err++;
         $display("FAIL reset_mid_mc: got %b want %b", obs, 6'b0);
      end
      model_reset();
      @(posedge clk_i);
      #1;
      reset_i = 1;
      ex_redirect_i = 0;
      // x12 was in flight before reset; scoreboard must now be clear.
      settle();
      n_vec++;
      if (obs !== 6'b0 || obs !== exp_vec()) begin
         n_err++;
         $display("FAIL sb_cleared: got %b want %b", obs, 6'b0);
      end
      advance();
   endtask

   task automatic test_random();
      logic [5:0] want;
      for (int c = 0; c < 600; c++) begin
         drive_random();
         settle();
         exp_q.push_back(exp_vec());
         want = exp_q.pop_front();
         n_vec++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL random cyc %0d: got %b want %b", c, obs, want);
         end
         advance();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_raw_stall();
      test_load_use();
      test_mc_done();
      test_redirect_raw();
      test_same_cycle_x9();
      test_mc_timeout();
      test_reset_mid_mc();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the PSRV32 5-stage pipeline (IF/ID/EX/MEM/WB).
- Keeps a register scoreboard of in-flight destination writes and detects RAW hazards against the instruction in decode.
- Holds the front end while a multi-cycle EX unit (mul/div) is busy, and squashes wrong-path instructions on an EX redirect.
- Drives the stall_i inputs of the IF and ID stages and the bubble/flush controls of ID/EX.

Parameters:
- NUM_REGS, 32, architectural register count; index width is log2(NUM_REGS).
- MC_TIMEOUT, 64, maximum cycles a multi-cycle op may stay busy before the error flag is raised.
- SB_CNT_W, 2, width of the per-register in-flight counter (saturation level 3).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  decode stage holds a valid instruction.
- id_rs1_i  in  5  decode operand-1 address.
- id_rs2_i  in  5  decode operand-2 address.
- id_rs1_use_i  in  1  rs1 is read.
- id_rs2_use_i  in  1  rs2 is read.
- id_rd_i  in  5  decode destination.
- id_rd_we_i  in  1  decode instruction writes rd.
- ex_rd_i  in  5  EX destination.
- ex_is_load_i  in  1  EX instruction is a load.
- ex_mc_start_i  in  1  multi-cycle op starts this cycle.
- ex_mc_done_i  in  1  multi-cycle op result ready.
- ex_redirect_i  in  1  EX resolved a taken branch or jump.
- wb_rd_i  in  5  WB destination.
- wb_we_i  in  1  WB writes the register file.
- stall_if_o  out  1  hold the PC and IF/ID register.
- stall_id_o  out  1  hold the ID stage.
- bubble_ex_o  out  1  insert a NOP into ID/EX.
- flush_id_o  out  1  kill the IF/ID contents.
- mc_busy_o  out  1  multi-cycle op in progress.
- mc_timeout_o  out  1  sticky timeout error.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - All scoreboard counters cleared; FSM goes to RUN; timeout counter cleared; mc_timeout_o cleared.
  - All outputs are 0.
- Register x0 is never tracked: it is never set and never causes a hazard.
- Issue definition: issue = id_valid_i & ~stall_id_o & ~flush_id_o.
- Scoreboard update, per register r, per cycle:
  - Increment when issue & id_rd_we_i & id_rd_i==r.
  - Decrement when wb_we_i & wb_rd_i==r.
  - Increment and decrement of the same r in one cycle: no change.
  - Saturates at 3 and floors at 0; neither limit is reachable in legal operation.
- RAW hazard (non-forwarding build): raw = id_valid_i & ((id_rs1_use_i & cnt[rs1]!=0) | (id_rs2_use_i & cnt[rs2]!=0)), with rs==0 excluded.
- FSM states:
  - RUN: outputs follow combinational priority.
  - MC_WAIT: entered on ex_mc_start_i.
    - While in MC_WAIT: stall_if_o=stall_id_o=1, mc_busy_o=1, bubble_ex_o=0 (EX is held by the MC unit).
    - Exit to RUN on ex_mc_done_i; the front end releases in the same cycle done is seen.
    - The timeout counter increments each MC_WAIT cycle. On reaching MC_TIMEOUT, mc_timeout_o is set (sticky until reset) and the FSM forces a return to RUN.
- Output priority in RUN, from highest to lowest:
  1. ex_redirect_i: flush_id_o=1 and bubble_ex_o=1, no stall. A redirect overrides any pending RAW stall. A redirect arriving with ex_mc_start_i is illegal; redirect wins and MC is ignored.
  2. ex_mc_start_i: enter MC_WAIT, stall asserted from the next cycle.
  3. raw: stall_if_o=stall_id_o=1, bubble_ex_o=1. This repeats every cycle until the scoreboard clears.
- Combinational paths from inputs to the stall, bubble and flush outputs are allowed. Scoreboard and FSM state are registered, so a scoreboard change takes effect one cycle later.

Optional Feature:
- Macro: PSRV_HAZARD_FWD_EN.
- Defined: a full forwarding network exists.
  - The scoreboard is not used for stalls; it still tracks for debug.
  - raw = id_valid_i & ex_is_load_i & ex_rd_i!=0 & ((rs1 use & ex_rd_i==id_rs1_i) | (rs2 use & ex_rd_i==id_rs2_i)).
  - This gives exactly one bubble per load-use.
- Undefined: the scoreboard RAW rule above applies.

Decomposition:
- Shared package psrv_pipe_pkg holds:
  - The FSM state enum (RUN, MC_WAIT).
  - REG_ADDR_W=5.
  - The x0 index constant.
  - The default MC_TIMEOUT.
- One natural sub-module, psrv_scoreboard, contains the counter array, the update rules and the two read ports.

Test Plan:
1. Reset released; issue add x5 with rd_we=1; next cycle decode reads x5 (non-fwd) -> stall_if_o=stall_id_o=bubble_ex_o=1 until wb_we_i with wb_rd_i=5, then 0 the cycle after.
2. With PSRV_HAZARD_FWD_EN: EX load to x7 and ID reads rs2=7 -> exactly one cycle of stall plus bubble; ALU producer to x7 -> no stall.
3. ex_mc_start_i pulse, ex_mc_done_i 10 cycles later -> mc_busy_o high 10 cycles, stalls released on the done cycle, mc_timeout_o=0.
4. ex_mc_start_i with no done and MC_TIMEOUT=64 -> mc_timeout_o=1 at cycle 64, FSM back to RUN, flag stays set until reset_i=0.
5. ex_redirect_i concurrent with a RAW stall -> flush_id_o=bubble_ex_o=1, stall_if_o=0 that cycle.
6. Same-cycle WB decrement and issue increment on x9 -> counter unchanged; reset_i pulled low mid-MC_WAIT -> all outputs 0 immediately, scoreboard cleared.
